// File: rtl/bist_sequencer.sv
// Self-test stimulus sequencer: walks an 8-bit vector through all 256 values,
// holding each for HOLD cycles, and folds the unit response into a 16-bit MISR.
module bist_sequencer #(
  parameter int unsigned HOLD = 4,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  resp,
  output logic        a,
  output logic        b,
  output logic        s,
  output logic [2:0]  c,
  output logic [1:0]  d,
  output logic        sample,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  localparam int HCNT_W = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [HCNT_W-1:0] HLAST = HCNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [7:0]          vec, vec_nx;
  logic [HCNT_W-1:0]   hcnt, hcnt_nx;
  logic [15:0]         sig, sig_nx;
  logic                last_hold;

  // CRC-CCITT style shift with the response XORed into the low byte.
  function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [7:0] din);
    logic [15:0] shifted;
    shifted = {cur[14:0], 1'b0} ^ (cur[15] ? 16'h1021 : 16'h0000);
    return shifted ^ {8'h00, din};
  endfunction

  assign last_hold = (state == RUN) && (hcnt == HLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= 8'h00;
      hcnt  <= '0;
      sig   <= SEED;
    end else begin
      state <= state_nx;
      vec   <= vec_nx;
      hcnt  <= hcnt_nx;
      sig   <= sig_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    hcnt_nx  = hcnt;
    sig_nx   = sig;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          vec_nx   = 8'h00;
          hcnt_nx  = '0;
          sig_nx   = SEED;
        end
      end
      RUN: begin
        if (last_hold) begin
          hcnt_nx = '0;
          sig_nx  = misr_next(sig, resp);
          if (vec == 8'hFF) begin
            // Park the vector at zero so the units see quiet inputs in DONE.
            state_nx = DONE;
            vec_nx   = 8'h00;
          end else begin
            vec_nx = vec + 8'd1;
          end
        end else begin
          hcnt_nx = hcnt + HCNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign a         = vec[0];
  assign b         = vec[1];
  assign s         = vec[2];
  assign c         = vec[5:3];
  assign d         = vec[7:6];
  assign sample    = last_hold;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign signature = sig;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: three instances (HOLD=1,2,4) share clock and reset.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // HOLD=1 instance
  logic start1 = 1'b1;
  logic [7:0] resp1;
  logic resp1_mode = 1'b0;
  logic [7:0] resp1_k = 8'h00;
  logic a1, b1, s1, smp1, busy1, done1;
  logic [2:0] c1;
  logic [1:0] d1;
  logic [15:0] sig1;

  // HOLD=2 instance
  logic start2 = 1'b1;
  logic [7:0] resp2 = 8'h00;
  logic a2, b2, s2, smp2, busy2, done2;
  logic [2:0] c2;
  logic [1:0] d2;
  logic [15:0] sig2;

  // HOLD=4 instance
  logic start4 = 1'b1;
  logic [7:0] resp4 = 8'h00;
  logic a4, b4, s4, smp4, busy4, done4;
  logic [2:0] c4;
  logic [1:0] d4;
  logic [15:0] sig4;

  bist_sequencer #(.HOLD(1), .SEED(16'hFFFF)) u1 (
    .clk(clk), .rst(rst), .start(start1), .resp(resp1),
    .a(a1), .b(b1), .s(s1), .c(c1), .d(d1),
    .sample(smp1), .busy(busy1), .done(done1), .signature(sig1));

  bist_sequencer #(.HOLD(2), .SEED(16'hFFFF)) u2 (
    .clk(clk), .rst(rst), .start(start2), .resp(resp2),
    .a(a2), .b(b2), .s(s2), .c(c2), .d(d2),
    .sample(smp2), .busy(busy2), .done(done2), .signature(sig2));

  bist_sequencer #(.HOLD(4), .SEED(16'hFFFF)) u4 (
    .clk(clk), .rst(rst), .start(start4), .resp(resp4),
    .a(a4), .b(b4), .s(s4), .c(c4), .d(d4),
    .sample(smp4), .busy(busy4), .done(done4), .signature(sig4));

  // Stand-in for the downstream units: comparator, mux, encoder, demux bits.
  function automatic logic [7:0] unit_resp(input logic [7:0] v);
    logic [7:0] r;
    r[0] = v[0] & ~v[1];
    r[1] = ~(v[0] ^ v[1]);
    r[2] = v[2] ? v[1] : v[0];
    r[3] = (v[5:3] == 3'd5);
    r[5:4] = v[5] ? 2'd2 : (v[4] ? 2'd1 : 2'd0);
    r[6] = (v[7:6] == 2'd1) & v[0];
    r[7] = (v[7:6] == 2'd3) & v[1];
    return r;
  endfunction

  always_comb resp1 = resp1_mode ? unit_resp({d1, c1, s1, b1, a1}) : resp1_k;

  function automatic logic [15:0] misr_step(input logic [15:0] sg, input logic [7:0] r);
    logic [15:0] t;
    t = sg << 1;
    if (sg[15]) t = t ^ 16'h1021;
    return t ^ {8'h00, r};
  endfunction

  function automatic logic [15:0] model_pass(input logic mode, input logic [7:0] k);
    logic [15:0] sg;
    sg = 16'hFFFF;
    for (int n = 0; n < 256; n++) sg = misr_step(sg, mode ? unit_resp(n[7:0]) : k);
    return sg;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One HOLD=1 pass from IDLE/DONE; reports final signature, busy and sample counts.
  task automatic pass1(output logic [15:0] sig_o, output int busy_n, output int smp_n);
    busy_n = 0;
    smp_n  = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      if (done1) break;
      if (busy1) busy_n++;
      if (busy1 && smp1) smp_n++;
      tick();
    end
    chk("u1_pass_done", done1, 1);
    sig_o = sig1;
  endtask

  typedef struct {
    logic [7:0]  resp;
    logic [7:0]  vec;
    logic        smp;
    logic        busy;
    logic        done;
    logic [15:0] sig;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [15:0] sg_a, sg_b, sg_c, sg_d;
    int busy_n, smp_n, vec_err, a_tog, d_tog, done_t;
    logic prev_busy, prev_a;
    logic [1:0] prev_d;
    logic [7:0] v;

    tbl[0] = '{8'h00, 8'd0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    tbl[1] = '{8'h00, 8'd1, 1'b1, 1'b1, 1'b0, 16'hEFDF};
    tbl[2] = '{8'hA5, 8'd2, 1'b1, 1'b1, 1'b0, 16'hCF9F};
    tbl[3] = '{8'h00, 8'd3, 1'b1, 1'b1, 1'b0, 16'h8FBA};
    tbl[4] = '{8'h00, 8'd4, 1'b1, 1'b1, 1'b0, 16'h0F55};
    tbl[5] = '{8'h00, 8'd5, 1'b1, 1'b1, 1'b0, 16'h1EAA};

    // Reset with start held high: rst wins.
    tick();
    tick();
    chk("rst_stim", {d4, c4, s4, b4, a4}, 8'h00);
    chk("rst_flags", {smp4, busy4, done4}, 3'b000);
    chk("rst_sig", sig4, 16'hFFFF);
    chk("rst_u1_flags", {smp1, busy1, done1}, 3'b000);
    rst = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    tick();
    chk("idle_busy", busy1, 0);

    // Table: first cycles of a HOLD=1 pass with chosen responses.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    foreach (tbl[i]) begin
      resp1_k = tbl[i].resp;
      #1;
      chk($sformatf("tbl%0d_vec", i), {d1, c1, s1, b1, a1}, tbl[i].vec);
      chk($sformatf("tbl%0d_flags", i), {smp1, busy1, done1}, {tbl[i].smp, tbl[i].busy, tbl[i].done});
      chk($sformatf("tbl%0d_sig", i), sig1, tbl[i].sig);
      tick();
    end
    resp1_k = 8'h00;
    for (int t = 0; t < 400 && !done1; t++) tick();
    chk("tbl_pass_done", done1, 1);

    // Signatures with constant responses, then with unit-derived responses.
    pass1(sg_a, busy_n, smp_n);
    chk("sig00", sg_a, model_pass(1'b0, 8'h00));
    chk("sig00_busy", busy_n, 256);
    chk("sig00_smp", smp_n, 256);
    resp1_k = 8'hA5;
    pass1(sg_b, busy_n, smp_n);
    chk("sigA5", sg_b, model_pass(1'b0, 8'hA5));
    chk("sig_differ", (sg_a != sg_b), 1);
    resp1_mode = 1'b1;
    pass1(sg_c, busy_n, smp_n);
    pass1(sg_d, busy_n, smp_n);
    chk("sig_unit", sg_c, model_pass(1'b1, 8'h00));
    chk("sig_unit_repeat", sg_d, sg_c);
    chk("done_stim_zero", {d1, c1, s1, b1, a1}, 8'h00);

    // Back-to-back: start held through DONE.
    start1 = 1'b1;
    tick();
    for (int t = 0; t < 400 && !done1; t++) tick();
    chk("b2b_done", done1, 1);
    tick();
    chk("b2b_done_1cyc", done1, 0);
    chk("b2b_busy", busy1, 1);
    chk("b2b_vec0", {d1, c1, s1, b1, a1}, 8'h00);
    chk("b2b_seed", sig1, 16'hFFFF);
    start1 = 1'b0;
    for (int t = 0; t < 400 && !done1; t++) tick();
    chk("b2b_sig", sig1, model_pass(1'b1, 8'h00));

    // HOLD=4 pass timing.
    busy_n = 0; smp_n = 0; vec_err = 0; a_tog = 0; d_tog = 0; done_t = 0;
    prev_busy = 1'b0; prev_a = 1'b0; prev_d = 2'd0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int t = 1; t <= 2000; t++) begin
      v = {d4, c4, s4, b4, a4};
      if (done4) begin
        done_t = t;
        break;
      end
      if (busy4) begin
        busy_n++;
        if (int'(v) != (t - 1) / 4) vec_err++;
        if (smp4) smp_n++;
        if (prev_busy && a4 != prev_a) a_tog++;
        if (prev_busy && d4 != prev_d) d_tog++;
      end
      prev_busy = busy4; prev_a = a4; prev_d = d4;
      tick();
    end
    chk("h4_busy_cycles", busy_n, 1024);
    chk("h4_samples", smp_n, 256);
    chk("h4_vec_err", vec_err, 0);
    chk("h4_a_toggles", a_tog, 255);
    chk("h4_d_changes", d_tog, 3);
    chk("h4_done_t", done_t, 1025);
    chk("h4_sig", sig4, model_pass(1'b0, 8'h00));
    chk("h4_busy_low", busy4, 0);

    // HOLD=2 pass with stray start pulses.
    vec_err = 0; done_t = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 1; t <= 1200; t++) begin
      if (done2) begin
        done_t = t;
        break;
      end
      if (busy2 && int'({d2, c2, s2, b2, a2}) != (t - 1) / 2) vec_err++;
      start2 = (t == 10 || t == 500);
      tick();
      start2 = 1'b0;
    end
    chk("h2_vec_err", vec_err, 0);
    chk("h2_done_t", done_t, 513);
    chk("h2_sig", sig2, model_pass(1'b0, 8'h00));

    // Reset at vector 37.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 200 && {d2, c2, s2, b2, a2} != 8'd37; t++) tick();
    chk("mid_vec37", {d2, c2, s2, b2, a2}, 8'd37);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_stim", {d2, c2, s2, b2, a2}, 8'h00);
    chk("mid_rst_flags", {smp2, busy2, done2}, 3'b000);
    chk("mid_rst_sig", sig2, 16'hFFFF);
    tick();
    chk("mid_idle", busy2, 0);
    smp_n = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 1200 && !done2; t++) begin
      if (busy2 && smp2) smp_n++;
      tick();
    end
    chk("mid_re_done", done2, 1);
    chk("mid_re_samples", smp_n, 256);
    chk("mid_re_sig", sig2, model_pass(1'b0, 8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bist_sequencer.md
# bist_sequencer

Self-test sequencer that sits directly upstream of the combinational and register units (comparator, encoder, decoder, mux, demux, dff). It drives their shared stimulus nets (a, b, s, c, d) through every input combination and holds each vector for a programmable number of cycles. At the end of each hold window it samples the units' collected response bus into a 16-bit multiple-input signature register (MISR). One pass covers 256 vectors; the final signature is compared against a golden value by the integrator.

## Interface

**Parameters**
- HOLD, default 4: cycles each vector is held. Legal range 1..255.
- SEED, default 16'hFFFF: signature reset/start value.

**Ports**
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, synchronous and active-high. Sampled on the rising edge of clk.
- start, input, 1: begin a pass. Sampled only in IDLE and DONE.
- resp, input, 8: unit response bus. Bit mapping is fixed by the integrator.
- a, output, 1: stimulus, vector bit 0.
- b, output, 1: stimulus, vector bit 1.
- s, output, 1: stimulus, vector bit 2.
- c, output, 3: stimulus, vector bits 5:3.
- d, output, 2: stimulus, vector bits 7:6.
- sample, output, 1: high during the last cycle of each hold window. resp is folded into the signature at the end of that cycle.
- busy, output, 1: high while in RUN.
- done, output, 1: high in DONE, until the next start or rst.
- signature, output, 16: MISR contents.

## Operation

**Internal state**
- 8-bit vector register vec, with {d,c,s,b,a} = vec.
- Hold counter hcnt, ceil(log2(HOLD+1)) bits wide, minimum 1 bit.
- FSM with states IDLE, RUN, DONE.

**Reset** (rst=1 at a clock edge; rst has priority over everything, including start)
- Next state is IDLE.
- vec=0, hcnt=0.
- sample=0, busy=0, done=0.
- signature=SEED.

**IDLE**
- Stimulus outputs are 0.
- On start=1: go to RUN, with vec=0, hcnt=0, signature=SEED.

**RUN**
- busy=1.
- When hcnt<HOLD-1: increment hcnt.
- When hcnt==HOLD-1:
  - sample=1 during that cycle (combinational decode of registered state).
  - At the closing edge, update signature as: next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {8'h00, resp}.
  - Reset hcnt to 0.
  - If vec==8'hFF, go to DONE; otherwise increment vec.
- start is ignored in RUN.

**DONE**
- done=1, busy=0.
- vec returns to 0, so stimulus outputs are 0.
- signature is frozen.
- On start=1: go to RUN, reseed the signature and clear done.

**Width rules**
- vec never wraps inside a pass. The 8'hFF case exits to DONE.
- hcnt compares against HOLD-1. With HOLD=1, sample is high on every RUN cycle.

## Timing

- start sampled at edge E0: busy=1 and vector 0 are visible in the cycle after E0.
- Vector n is driven in cycles E0+n·HOLD+1 through E0+(n+1)·HOLD.
- sample is high in the last of those cycles.
- The signature absorbs vector n's response at edge E0+(n+1)·HOLD.
- done rises (and busy falls) after edge E0+256·HOLD. Pass length is exactly 256·HOLD cycles of busy.
- Exactly 256 sample pulses occur per pass.
- Stimulus outputs are registered, with no combinational path from inputs to stimulus.
- resp is expected to settle within one cycle of a stimulus change. With HOLD≥2 the unit outputs have at least one full cycle to settle before sampling.
- rst mid-pass: after that edge, all outputs take reset values and the pass is abandoned.
- start and rst high on the same edge: IDLE, no pass begins.
- start held high across DONE: restarts immediately; done is high for one cycle only.

## Test plan

- **Reset values.** Assert rst 2 cycles with start=1 -> a=b=s=0, c=0, d=0, busy=0, done=0, sample=0, signature=16'hFFFF.
- **Pass timing, HOLD=4.** Pulse start once -> busy high exactly 1024 cycles. a toggles every 4 cycles, d changes every 256 cycles. 256 sample pulses. done rises 1025 cycles after the start edge.
- **Signature.** HOLD=1, resp tied to {a,b,s,c,d}-independent constant 8'h00, then 8'hA5 on a second pass -> signature matches the bench MISR model for both passes, and the two results differ. Repeat with resp driven by real unit outputs -> deterministic and repeatable across two passes.
- **Start ignored while running.** Extra start pulses at cycles 10 and 500 of a HOLD=2 pass -> no change to vec progression. done at cycle 513.
- **Reset mid-pass.** rst at vector 37 -> outputs return to reset values the next cycle. A later start gives a full 256-vector pass with the signature reseeded.
- **Back-to-back.** start held high through done -> done high exactly 1 cycle, then a new pass with vector 0 and signature=SEED.
